// File: rtl/param_register_file.sv
// param_register_file: parametrised CPU register file with write enable,
// optional hard-wired zero register (ZERO_REG) and a sequential clear engine
// that zeroes one entry per cycle after reset or on ClearReq.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle write-through
// forwarding on the read ports while Ready=1.
module param_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int FLAGS_ADDR = 7,
    parameter int ZERO_REG   = 0
) (
    input  logic                                   Clk,
    input  logic                                   Reset,
    input  logic                                   ClearReq,
    input  logic                                   WriteEn,
    input  logic [ADDR_WIDTH-1:0]                  AddrA,
    input  logic [ADDR_WIDTH-1:0]                  AddrB,
    input  logic [ADDR_WIDTH-1:0]                  AddrC,
    input  logic [DATA_WIDTH-1:0]                  InDataA,
    input  logic [DATA_WIDTH-1:0]                  InNewFlags,
    input  logic                                   UpdateFlags,
    output logic [DATA_WIDTH-1:0]                  OutDataB,
    output logic [DATA_WIDTH-1:0]                  OutDataC,
    output logic [DATA_WIDTH-1:0]                  OutFlags,
    output logic                                   Ready,
    output logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0]  DebugData
);
    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] FLAGS_IDX = ADDR_WIDTH'(FLAGS_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clearPtr;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  dataWrite;
    logic                  flagsWrite;

    // Qualified write strobes: only in normal operation, not on a clear request,
    // and never into a hard-wired zero entry.
    always_comb begin
        dataWrite  = Ready && !ClearReq && WriteEn
                     && !(HAS_ZERO && AddrA == '0);
        flagsWrite = Ready && !ClearReq && UpdateFlags
                     && !(HAS_ZERO && FLAGS_IDX == '0);
    end

    // Clear/ready sequencer: walk clearPtr over every entry, then go ready.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= CLEAR;
            clearPtr <= '0;
            Ready    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clearPtr <= clearPtr + ADDR_WIDTH'(1);
                    if (clearPtr == LAST_IDX) begin
                        state <= READY;
                        Ready <= 1'b1;
                    end
                end
                READY: begin
                    if (ClearReq) begin
                        state    <= CLEAR;
                        clearPtr <= '0;
                        Ready    <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage: no parallel reset; cleared one entry per cycle by the engine.
    // The flags write is issued last so it wins when AddrA == FLAGS_ADDR.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state == CLEAR) begin
                regs[clearPtr] <= '0;
            end else begin
                if (dataWrite)  regs[AddrA]     <= InDataA;
                if (flagsWrite) regs[FLAGS_IDX] <= InNewFlags;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] storedValue(input logic [ADDR_WIDTH-1:0] addr);
        if (HAS_ZERO && addr == '0) return '0;
        return regs[addr];
    endfunction

    // Read ports: zero while clearing, otherwise stored (optionally forwarded) data.
    always_comb begin
        OutDataB = '0;
        OutDataC = '0;
        OutFlags = '0;
        if (Ready) begin
            OutDataB = storedValue(AddrB);
            OutDataC = storedValue(AddrC);
            OutFlags = storedValue(FLAGS_IDX);
`ifdef REGFILE_BYPASS_EN
            // Flags forward is applied after data forward to match write priority.
            if (dataWrite && AddrB == AddrA) OutDataB = InDataA;
            if (dataWrite && AddrC == AddrA) OutDataC = InDataA;
            if (flagsWrite) begin
                OutFlags = InNewFlags;
                if (AddrB == FLAGS_IDX) OutDataB = InNewFlags;
                if (AddrC == FLAGS_IDX) OutDataC = InNewFlags;
            end
`endif
        end
    end

    // Raw storage view, unmasked by Ready; the zero entry always reads zero.
    always_comb begin
        DebugData = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            DebugData[i*DATA_WIDTH +: DATA_WIDTH] = regs[ADDR_WIDTH'(i)];
        end
        if (HAS_ZERO) DebugData[DATA_WIDTH-1:0] = '0;
    end

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int FLAGS = 7;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Reset, ClearReq, WriteEn, UpdateFlags;
  logic [AW-1:0] AddrA, AddrB, AddrC;
  logic [DW-1:0] InDataA, InNewFlags;

  logic [1:0][DW-1:0]       outB, outC, outF;
  logic [1:0]               rdy;
  logic [1:0][DW*DEPTH-1:0] dbg;

  param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLAGS_ADDR(FLAGS), .ZERO_REG(0)) dut (
    .Clk(Clk), .Reset(Reset), .ClearReq(ClearReq), .WriteEn(WriteEn),
    .AddrA(AddrA), .AddrB(AddrB), .AddrC(AddrC), .InDataA(InDataA),
    .InNewFlags(InNewFlags), .UpdateFlags(UpdateFlags),
    .OutDataB(outB[0]), .OutDataC(outC[0]), .OutFlags(outF[0]),
    .Ready(rdy[0]), .DebugData(dbg[0]));

  param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLAGS_ADDR(FLAGS), .ZERO_REG(1)) dutZ (
    .Clk(Clk), .Reset(Reset), .ClearReq(ClearReq), .WriteEn(WriteEn),
    .AddrA(AddrA), .AddrB(AddrB), .AddrC(AddrC), .InDataA(InDataA),
    .InNewFlags(InNewFlags), .UpdateFlags(UpdateFlags),
    .OutDataB(outB[1]), .OutDataC(outC[1]), .OutFlags(outF[1]),
    .Ready(rdy[1]), .DebugData(dbg[1]));

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mdl [2][DEPTH];
  bit            mReady [2];
  int            mPtr [2];

  task automatic modelStep(input int k);
    if (Reset) begin
      mReady[k] = 1'b0;
      mPtr[k]   = 0;
    end else if (!mReady[k]) begin
      mdl[k][mPtr[k]] = '0;
      mPtr[k]++;
      if (mPtr[k] == DEPTH) mReady[k] = 1'b1;
    end else if (ClearReq) begin
      mReady[k] = 1'b0;
      mPtr[k]   = 0;
    end else begin
      if (WriteEn && !(k == 1 && AddrA == 0)) mdl[k][AddrA] = InDataA;
      if (UpdateFlags) mdl[k][FLAGS] = InNewFlags;
    end
  endtask

  function automatic logic [DW-1:0] expRead(input int k, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!mReady[k]) return '0;
    v = (k == 1 && a == 0) ? '0 : mdl[k][a];
`ifdef REGFILE_BYPASS_EN
    if (!ClearReq) begin
      if (WriteEn && a == AddrA && !(k == 1 && a == 0)) v = InDataA;
      if (UpdateFlags && a == FLAGS) v = InNewFlags;
    end
`endif
    return v;
  endfunction

  function automatic logic [DW-1:0] expFlags(input int k);
    logic [DW-1:0] v;
    if (!mReady[k]) return '0;
    v = mdl[k][FLAGS];
`ifdef REGFILE_BYPASS_EN
    if (!ClearReq && UpdateFlags) v = InNewFlags;
`endif
    return v;
  endfunction

  function automatic logic [DW*DEPTH-1:0] expDebug(input int k);
    logic [DW*DEPTH-1:0] v;
    for (int unsigned i = 0; i < DEPTH; i++) v[i*DW +: DW] = mdl[k][i];
    if (k == 1) v[DW-1:0] = '0;
    return v;
  endfunction

  task automatic tick();
    @(posedge Clk);
    modelStep(0);
    modelStep(1);
    #1;
  endtask

  task automatic test_reset();
    int n;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (rdy !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 00", rdy);
    end
    n = 0;
    while (rdy[0] !== 1'b1 && n < 20) begin
      checks++;
      if (outF[0] !== '0 || outB[0] !== '0) begin
        errors++;
        $display("FAIL reset_reads_zero: flags %h dataB %h expected 0", outF[0], outB[0]);
      end
      tick();
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL reset_ready_latency: got %0d cycles expected 8", n);
    end
    checks++;
    if (rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_zero_inst: got %b expected 1", rdy[1]);
    end
    for (int unsigned k = 0; k < 2; k++) begin
      checks++;
      if (dbg[k] !== '0) begin
        errors++;
        $display("FAIL reset_debug_zero[%0d]: got %h expected 0", k, dbg[k]);
      end
      checks++;
      if (outF[k] !== '0) begin
        errors++;
        $display("FAIL reset_flags_zero[%0d]: got %h expected 0", k, outF[k]);
      end
    end
  endtask

  task automatic test_write_read();
    AddrA = 3; InDataA = 16'hBEEF; WriteEn = 1'b1; AddrB = 3; AddrC = 3;
    #1;
    checks++;
    if (outB[0] !== expRead(0, 3)) begin
      errors++;
      $display("FAIL write_cycle_portB: got %h expected %h", outB[0], expRead(0, 3));
    end
    tick();
    WriteEn = 1'b0;
    #1;
    checks++;
    if (outB[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_after_write_B: got %h expected beef", outB[0]);
    end
    checks++;
    if (outC[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_after_write_C: got %h expected beef", outC[0]);
    end
  endtask

  task automatic test_flags_priority();
    AddrA = 7; InDataA = 16'h1111; WriteEn = 1'b1;
    InNewFlags = 16'h00A5; UpdateFlags = 1'b1;
    tick();
    WriteEn = 1'b0; UpdateFlags = 1'b0;
    #1;
    for (int unsigned k = 0; k < 2; k++) begin
      checks++;
      if (outF[k] !== 16'h00A5) begin
        errors++;
        $display("FAIL flags_priority_out[%0d]: got %h expected 00a5", k, outF[k]);
      end
      checks++;
      if (dbg[k][7*DW +: DW] !== 16'h00A5) begin
        errors++;
        $display("FAIL flags_priority_entry7[%0d]: got %h expected 00a5", k, dbg[k][7*DW +: DW]);
      end
    end
  endtask

  task automatic test_clear_req();
    int n;
    for (int unsigned r = 1; r < 8; r++) begin
      AddrA = AW'(r); InDataA = DW'(r); WriteEn = 1'b1;
      tick();
    end
    WriteEn = 1'b0; AddrB = 2; AddrC = 5;
    #1;
    checks++;
    if (outB[0] !== 16'h0002 || outC[0] !== 16'h0005) begin
      errors++;
      $display("FAIL fill_readback: got %h/%h expected 0002/0005", outB[0], outC[0]);
    end
    ClearReq = 1'b1; WriteEn = 1'b1; AddrA = 2; InDataA = 16'hFFFF;
    tick();
    ClearReq = 1'b0; WriteEn = 1'b0;
    #1;
    checks++;
    if (rdy !== 2'b00) begin
      errors++;
      $display("FAIL clear_ready_low: got %b expected 00", rdy);
    end
    checks++;
    if (dbg[0][2*DW +: DW] !== 16'h0002) begin
      errors++;
      $display("FAIL clear_write_dropped: got %h expected 0002", dbg[0][2*DW +: DW]);
    end
    n = 0;
    while (rdy[0] !== 1'b1 && n < 20) begin
      checks++;
      if (outB[0] !== '0 || outC[0] !== '0 || outF[0] !== '0) begin
        errors++;
        $display("FAIL clear_reads_zero: got %h/%h/%h expected 0", outB[0], outC[0], outF[0]);
      end
      checks++;
      if (dbg[0] !== expDebug(0)) begin
        errors++;
        $display("FAIL clear_partial_debug: got %h expected %h", dbg[0], expDebug(0));
      end
      ClearReq = (n == 3);
      WriteEn = (n == 4); AddrA = 4; InDataA = 16'h4444;
      tick();
      ClearReq = 1'b0; WriteEn = 1'b0;
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL clear_latency: got %0d cycles expected 8", n);
    end
    for (int unsigned k = 0; k < 2; k++) begin
      checks++;
      if (dbg[k] !== '0) begin
        errors++;
        $display("FAIL clear_all_zero[%0d]: got %h expected 0", k, dbg[k]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    for (int unsigned r = 0; r < 8; r++) begin
      AddrA = AW'(r); InDataA = 16'hA0 + DW'(r); WriteEn = 1'b1;
      tick();
    end
    WriteEn = 1'b0;
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      checks++;
      if (dbg[k] !== expDebug(k)) begin
        errors++;
        $display("FAIL midclear_contents[%0d]: got %h expected %h", k, dbg[k], expDebug(k));
      end
    end
    n = 0;
    while (rdy[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL midclear_ready_latency: got %0d cycles expected 8", n);
    end
    checks++;
    if (dbg[0] !== '0) begin
      errors++;
      $display("FAIL midclear_all_zero: got %h expected 0", dbg[0]);
    end
  endtask

  task automatic test_zero_reg();
    AddrA = 0; InDataA = 16'h1234; WriteEn = 1'b1;
    tick();
    WriteEn = 1'b0; AddrB = 0; AddrC = 0;
    #1;
    checks++;
    if (outB[1] !== '0) begin
      errors++;
      $display("FAIL zero_reg_read: got %h expected 0", outB[1]);
    end
    checks++;
    if (dbg[1][DW-1:0] !== '0) begin
      errors++;
      $display("FAIL zero_reg_debug: got %h expected 0", dbg[1][DW-1:0]);
    end
    checks++;
    if (outB[0] !== 16'h1234) begin
      errors++;
      $display("FAIL nonzero_inst_entry0: got %h expected 1234", outB[0]);
    end
  endtask

  task automatic test_random();
    for (int unsigned it = 0; it < 400; it++) begin
      Reset       = ($urandom_range(0, 99) == 0);
      ClearReq    = ($urandom_range(0, 39) == 0);
      WriteEn     = ($urandom_range(0, 1) == 1);
      UpdateFlags = ($urandom_range(0, 3) == 0);
      AddrA       = AW'($urandom_range(0, DEPTH - 1));
      AddrB       = AW'($urandom_range(0, DEPTH - 1));
      AddrC       = AW'($urandom_range(0, DEPTH - 1));
      InDataA     = DW'($urandom);
      InNewFlags  = DW'($urandom);
      tick();
      for (int unsigned k = 0; k < 2; k++) begin
        checks++;
        if (rdy[k] !== mReady[k]) begin
          errors++;
          $display("FAIL rand_ready[%0d] it%0d: got %b expected %b", k, it, rdy[k], mReady[k]);
        end
        checks++;
        if (outB[k] !== expRead(k, AddrB)) begin
          errors++;
          $display("FAIL rand_portB[%0d] it%0d: got %h expected %h", k, it, outB[k], expRead(k, AddrB));
        end
        checks++;
        if (outC[k] !== expRead(k, AddrC)) begin
          errors++;
          $display("FAIL rand_portC[%0d] it%0d: got %h expected %h", k, it, outC[k], expRead(k, AddrC));
        end
        checks++;
        if (outF[k] !== expFlags(k)) begin
          errors++;
          $display("FAIL rand_flags[%0d] it%0d: got %h expected %h", k, it, outF[k], expFlags(k));
        end
        checks++;
        if (dbg[k] !== expDebug(k)) begin
          errors++;
          $display("FAIL rand_debug[%0d] it%0d: got %h expected %h", k, it, dbg[k], expDebug(k));
        end
      end
    end
    Reset = 1'b0; ClearReq = 1'b0; WriteEn = 1'b0; UpdateFlags = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; ClearReq = 1'b0; WriteEn = 1'b0; UpdateFlags = 1'b0;
    AddrA = '0; AddrB = '0; AddrC = '0; InDataA = '0; InNewFlags = '0;
    mReady[0] = 1'b0; mReady[1] = 1'b0; mPtr[0] = 0; mPtr[1] = 0;
    #2;
    test_reset();
    test_write_read();
    test_flags_priority();
    test_clear_req();
    test_reset_mid_clear();
    test_zero_reg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the CPU's 8x16 register file. Data width, depth and the flags-register index are configurable.
- Adds a write enable, an optional hard-wired zero register, and a sequential clear engine. The engine zeroes one entry per cycle after reset or on request, so the storage maps to distributed RAM without a wide parallel reset.
- Sits between decode (addresses) and ALU/writeback (data, flags). Ready gates the core's pipeline.

Parameters:
- DATA_WIDTH, 16, width of each register and of the flags word.
- ADDR_WIDTH, 3, register address width; DEPTH = 2**ADDR_WIDTH.
- FLAGS_ADDR, 7, index of the register used as flags; must be < DEPTH.
- ZERO_REG, 0, when 1, entry 0 always reads zero and writes to it are dropped.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- ClearReq  input  1  one-cycle pulse; starts a clear sequence when Ready=1.
- WriteEn  input  1  enables the write of InDataA to AddrA.
- AddrA  input  ADDR_WIDTH  write address.
- AddrB  input  ADDR_WIDTH  read port B address.
- AddrC  input  ADDR_WIDTH  read port C address.
- InDataA  input  DATA_WIDTH  write data.
- InNewFlags  input  DATA_WIDTH  new flags value.
- UpdateFlags  input  1  enables the write of InNewFlags to FLAGS_ADDR.
- OutDataB  output  DATA_WIDTH  read data, port B.
- OutDataC  output  DATA_WIDTH  read data, port C.
- OutFlags  output  DATA_WIDTH  current flags register.
- Ready  output  1  1 = clear finished, normal operation.
- DebugData  output  DATA_WIDTH*DEPTH  all entries concatenated; entry i at [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- One clock domain (Clk); reset is synchronous and active-high (Reset). The polarity and synchronicity are fixed.
- State machine: two states, CLEAR and READY, plus a ClearPtr counter of ADDR_WIDTH bits.
- Reset=1 at a posedge:
  - state <= CLEAR, ClearPtr <= 0, Ready <= 0.
  - Reset overrides everything, including a clear already in progress (the pointer restarts at 0).
- CLEAR state:
  - Each cycle: Data[ClearPtr] <= 0, then ClearPtr increments.
  - When ClearPtr == DEPTH-1, that entry is zeroed, state <= READY, Ready <= 1. A full clear takes DEPTH cycles, so Ready rises DEPTH cycles after Reset deasserts.
  - ClearPtr wraps naturally; no extra cycle is added.
- READY state:
  - ClearReq=1 -> state <= CLEAR, ClearPtr <= 0, Ready <= 0.
  - If a write is also requested in the same cycle, the write is dropped.
- While Ready=0:
  - WriteEn and UpdateFlags are ignored.
  - OutDataB, OutDataC and OutFlags read 0.
  - ClearReq is ignored.
- Writes (READY only), at posedge:
  - WriteEn=1 -> Data[AddrA] <= InDataA.
  - UpdateFlags=1 -> Data[FLAGS_ADDR] <= InNewFlags.
  - Both active with AddrA == FLAGS_ADDR: UpdateFlags wins.
- ZERO_REG=1:
  - Writes to entry 0 are dropped, including a write through UpdateFlags if FLAGS_ADDR==0.
  - Reads of entry 0 return 0.
  - DebugData slice 0 reads 0.
- Reads are combinational from the stored array. Without the optional feature, a write becomes visible on the read ports the cycle after its posedge.
- DebugData reflects raw storage at all times, including partially cleared contents during CLEAR. It is not masked by Ready.
- Storage contents before the first Reset are undefined. The bench must apply Reset before checking anything.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write-through forwarding while Ready=1.
  - If WriteEn=1 and AddrB/AddrC == AddrA (and not the dropped zero register), OutDataB/OutDataC = InDataA combinationally.
  - If UpdateFlags=1, OutFlags, and any read port addressing FLAGS_ADDR, show InNewFlags.
  - The flags forward takes priority over the data forward, matching write priority.
- Undefined: no forwarding; reads show stored values only; one-cycle write-to-read latency.

Test Plan:
- Reset 1 cycle, defaults -> Ready=0 for exactly 8 cycles after Reset falls, then 1; all DebugData slices 0; OutFlags=0.
- Ready=1; WriteEn, AddrA=3, InDataA=16'hBEEF; next cycle AddrB=3, AddrC=3 -> OutDataB = OutDataC = 16'hBEEF. With REGFILE_BYPASS_EN, the value also appears in the write cycle.
- WriteEn with AddrA=7, InDataA=16'h1111, and UpdateFlags with InNewFlags=16'h00A5 in the same cycle -> OutFlags=16'h00A5 and Data[7]=16'h00A5.
- Fill regs 1..7 with 16'h0001..16'h0007, pulse ClearReq together with WriteEn(AddrA=2, 16'hFFFF) -> write dropped; Ready low 8 cycles; reads 0 throughout; all entries 0 afterwards.
- Assert Reset at clear cycle 4, hold 1 cycle -> clear restarts at ptr 0; Ready rises 8 cycles after Reset falls.
- ZERO_REG=1: WriteEn AddrA=0, 16'h1234 -> OutDataB (AddrB=0) = 0, DebugData[15:0] = 0.
